// File: rtl/up_down_counter_sweep_pkg.sv
// Shared widths and FSM state type for the up/down counter sweep controller.
package up_down_counter_sweep_pkg;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/up_down_counter_sweep_ctrl_if.sv
// Host command, status and counter-link signals of the sweep controller.
interface up_down_counter_sweep_ctrl_if
   import up_down_counter_sweep_pkg::*;
#(
   parameter int unsigned P_WIDTH = WIDTH,
   parameter int unsigned P_CNT_W = CNT_W
);
   logic               start;
   logic               stop;
   logic [P_WIDTH-1:0] lo_bound;
   logic [P_WIDTH-1:0] hi_bound;
   logic [P_CNT_W-1:0] num_sweeps;
   logic [P_WIDTH-1:0] count_val;
   logic               cnt_load;
   logic               cnt_up_down;
   logic [P_WIDTH-1:0] cnt_load_val;
   logic               busy;
   logic               done;
   logic               err;
   logic [P_CNT_W-1:0] sweep_cnt;

   // Host plus counter side
   modport master (
      output start, stop, lo_bound, hi_bound, num_sweeps, count_val,
      input  cnt_load, cnt_up_down, cnt_load_val, busy, done, err, sweep_cnt
   );

   // Controller side
   modport slave (
      input  start, stop, lo_bound, hi_bound, num_sweeps, count_val,
      output cnt_load, cnt_up_down, cnt_load_val, busy, done, err, sweep_cnt
   );
endinterface

// File: rtl/up_down_counter_sweep_ctrl.sv
// Drives a free-running loadable up/down counter through lo->hi->lo triangle
// sweeps a programmed number of times; parks it at lo whenever not sweeping.
module up_down_counter_sweep_ctrl
   import up_down_counter_sweep_pkg::*;
#(
   parameter int unsigned P_WIDTH = WIDTH,
   parameter int unsigned P_CNT_W = CNT_W
) (
   input  logic clk,
   input  logic rst,
   up_down_counter_sweep_ctrl_if.slave bus
);
   state_t             r_state;
   logic               r_dir;
   logic               r_first;
   logic               r_err;
   logic [P_WIDTH-1:0] r_lo;
   logic [P_WIDTH-1:0] r_hi;
   logic [P_CNT_W-1:0] r_num;
   logic [P_CNT_W-1:0] r_sweep_cnt;

   logic w_run;
   logic w_at_hi;
   logic w_at_lo;
   logic w_up_down;
   logic w_eval;
   logic w_stop;
   logic w_sweep_end;
   logic w_finish;
   logic w_valid_start;
   logic w_load;

   assign w_run   = (r_state == RUN);
   assign w_at_hi = (bus.count_val == r_hi);
   assign w_at_lo = (bus.count_val == r_lo);

   // Direction turns at the bounds with no registered lag; outside RUN it rests
   assign w_up_down = !w_run  ? r_dir :
                      w_at_hi ? 1'b0  :
                      w_at_lo ? 1'b1  : r_dir;

   // First RUN cycle still sees the old lo on the counter, so it only reloads
   assign w_eval        = w_run & ~r_first;
   assign w_stop        = w_run & bus.stop;
   assign w_sweep_end   = w_eval & ~r_dir & w_at_lo;
   assign w_finish      = w_sweep_end & (P_CNT_W'(r_sweep_cnt + P_CNT_W'(1)) == r_num);
   assign w_valid_start = (bus.lo_bound < bus.hi_bound) & (bus.num_sweeps != '0);
   assign w_load        = ~w_run | r_first | w_finish | w_stop;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_dir       <= 1'b1;
         r_first     <= 1'b0;
         r_err       <= 1'b0;
         r_lo        <= '0;
         r_hi        <= '0;
         r_num       <= '0;
         r_sweep_cnt <= '0;
      end else begin
         r_err   <= 1'b0;
         r_first <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (w_valid_start) begin
                     r_lo        <= bus.lo_bound;
                     r_hi        <= bus.hi_bound;
                     r_num       <= bus.num_sweeps;
                     r_sweep_cnt <= '0;
                     r_dir       <= 1'b1;
                     r_first     <= 1'b1;
                     r_state     <= RUN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_dir <= w_up_down;
               // Abort wins over a completing sweep in the same cycle
               if (w_stop) begin
                  r_state <= IDLE;
               end else if (w_sweep_end) begin
                  r_sweep_cnt <= P_CNT_W'(r_sweep_cnt + P_CNT_W'(1));
                  if (w_finish) r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cnt_load     = w_load;
   assign bus.cnt_up_down  = w_up_down;
   assign bus.cnt_load_val = r_lo;
   assign bus.busy         = w_run;
   assign bus.done         = (r_state == DONE);
   assign bus.err          = r_err;
   assign bus.sweep_cnt    = r_sweep_cnt;
endmodule

// File: tb/tb_up_down_counter_sweep_ctrl.sv
// Directed bench: sweep controller closed around a behavioural up/down counter.
module tb_up_down_counter_sweep_ctrl;
   import up_down_counter_sweep_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] r_count;
   int         n_tests;
   int         n_fail;

   up_down_counter_sweep_ctrl_if #(.P_WIDTH(WIDTH), .P_CNT_W(CNT_W)) u_if ();

   up_down_counter_sweep_ctrl #(.P_WIDTH(WIDTH), .P_CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   // Loadable up/down counter: counts every edge, no enable
   always_ff @(posedge clk) begin
      if (u_if.cnt_load)          r_count <= u_if.cnt_load_val;
      else if (u_if.cnt_up_down)  r_count <= r_count + 8'd1;
      else                        r_count <= r_count - 8'd1;
   end
   assign u_if.count_val = r_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_cmd(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] num);
      u_if.lo_bound   = lo;
      u_if.hi_bound   = hi;
      u_if.num_sweeps = num;
      u_if.start      = 1'b1;
      step();
      u_if.start      = 1'b0;
      #1;
   endtask

   logic [7:0] exp1 [7];
   logic       ud1  [7];
   logic [7:0] exp3 [19];
   logic [7:0] v_min;
   logic [7:0] v_max;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp1 = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd11, 8'd10};
      ud1  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      exp3 = '{8'h92, 8'h93, 8'h94, 8'h95, 8'h94, 8'h93, 8'h92,
               8'h93, 8'h94, 8'h95, 8'h94, 8'h93, 8'h92,
               8'h93, 8'h94, 8'h95, 8'h94, 8'h93, 8'h92};
      u_if.start      = 1'b0;
      u_if.stop       = 1'b0;
      u_if.lo_bound   = '0;
      u_if.hi_bound   = '0;
      u_if.num_sweeps = '0;
      rst             = 1'b0;

      // Reset and idle
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rst_load",     32'(u_if.cnt_load),     32'd1);
      chk("rst_ud",       32'(u_if.cnt_up_down),  32'd1);
      chk("rst_load_val", 32'(u_if.cnt_load_val), 32'd0);
      chk("rst_busy",     32'(u_if.busy),         32'd0);
      chk("rst_done",     32'(u_if.done),         32'd0);
      chk("rst_err",      32'(u_if.err),          32'd0);
      chk("rst_sweep",    32'(u_if.sweep_cnt),    32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_count", 32'(r_count),       32'd0);
         chk("idle_load",  32'(u_if.cnt_load), 32'd1);
         chk("idle_busy",  32'(u_if.busy),     32'd0);
      end

      // Single sweep 10..13
      start_cmd(8'd10, 8'd13, 8'd1);
      chk("s1_first_busy",  32'(u_if.busy),         32'd1);
      chk("s1_first_load",  32'(u_if.cnt_load),     32'd1);
      chk("s1_first_count", 32'(r_count),           32'd0);
      chk("s1_load_val",    32'(u_if.cnt_load_val), 32'd10);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("s1_count", 32'(r_count),          32'(exp1[i]));
         chk("s1_ud",    32'(u_if.cnt_up_down), 32'(ud1[i]));
         chk("s1_done",  32'(u_if.done),        32'd0);
      end
      chk("s1_finish_load", 32'(u_if.cnt_load), 32'd1);
      step();
      chk("s1_done_pulse", 32'(u_if.done),      32'd1);
      chk("s1_done_busy",  32'(u_if.busy),      32'd0);
      chk("s1_done_count", 32'(r_count),        32'd10);
      chk("s1_sweep_cnt",  32'(u_if.sweep_cnt), 32'd1);
      step();
      chk("s1_done_clear", 32'(u_if.done),      32'd0);
      chk("s1_park",       32'(r_count),        32'd10);

      // Three sweeps 0x92..0x95
      start_cmd(8'h92, 8'h95, 8'd3);
      chk("s3_first_count", 32'(r_count), 32'd10);
      v_min = 8'hff;
      v_max = 8'h00;
      for (int i = 0; i < 19; i++) begin
         step();
         chk("s3_count", 32'(r_count),   32'(exp3[i]));
         chk("s3_busy",  32'(u_if.busy), 32'd1);
         if (r_count < v_min) v_min = r_count;
         if (r_count > v_max) v_max = r_count;
         if (i == 7)  chk("s3_sweep1", 32'(u_if.sweep_cnt), 32'd1);
         if (i == 13) chk("s3_sweep2", 32'(u_if.sweep_cnt), 32'd2);
      end
      chk("s3_min", 32'(v_min), 32'h92);
      chk("s3_max", 32'(v_max), 32'h95);
      step();
      chk("s3_done",      32'(u_if.done),      32'd1);
      chk("s3_sweep_cnt", 32'(u_if.sweep_cnt), 32'd3);
      step();
      chk("s3_done_clear", 32'(u_if.done), 32'd0);
      chk("s3_park",       32'(r_count),   32'h92);

      // Rejected starts: lo==hi, then num==0
      start_cmd(8'd20, 8'd20, 8'd1);
      chk("e1_err",      32'(u_if.err),          32'd1);
      chk("e1_busy",     32'(u_if.busy),         32'd0);
      chk("e1_count",    32'(r_count),           32'h92);
      chk("e1_load_val", 32'(u_if.cnt_load_val), 32'h92);
      step();
      chk("e1_err_clear", 32'(u_if.err),  32'd0);
      chk("e1_busy2",     32'(u_if.busy), 32'd0);
      start_cmd(8'd1, 8'd5, 8'd0);
      chk("e2_err",      32'(u_if.err),          32'd1);
      chk("e2_busy",     32'(u_if.busy),         32'd0);
      chk("e2_load_val", 32'(u_if.cnt_load_val), 32'h92);
      step();
      chk("e2_err_clear", 32'(u_if.err), 32'd0);
      chk("e2_count",     32'(r_count),  32'h92);

      // Abort on the down slope
      start_cmd(8'd10, 8'd13, 8'd2);
      for (int i = 0; i < 5; i++) step();
      chk("st_pre_count", 32'(r_count), 32'd12);
      u_if.stop = 1'b1;
      #1;
      chk("st_load", 32'(u_if.cnt_load), 32'd1);
      step();
      u_if.stop = 1'b0;
      #1;
      chk("st_count", 32'(r_count),        32'd10);
      chk("st_busy",  32'(u_if.busy),      32'd0);
      chk("st_done",  32'(u_if.done),      32'd0);
      chk("st_sweep", 32'(u_if.sweep_cnt), 32'd0);
      step();
      chk("st_done2",  32'(u_if.done), 32'd0);
      chk("st_count2", 32'(r_count),   32'd10);

      // Reset mid-run, then a fresh run
      start_cmd(8'd10, 8'd13, 8'd1);
      step();
      step();
      step();
      chk("rr_pre_count", 32'(r_count), 32'd12);
      rst = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("rr_busy",     32'(u_if.busy),         32'd0);
      chk("rr_load",     32'(u_if.cnt_load),     32'd1);
      chk("rr_load_val", 32'(u_if.cnt_load_val), 32'd0);
      chk("rr_ud",       32'(u_if.cnt_up_down),  32'd1);
      chk("rr_sweep",    32'(u_if.sweep_cnt),    32'd0);
      step();
      chk("rr_park", 32'(r_count), 32'd0);
      start_cmd(8'd3, 8'd5, 8'd1);
      chk("rr_first_count", 32'(r_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_count", 32'(r_count), 32'((i < 3) ? (3 + i) : (7 - i)));
      end
      step();
      chk("rr_done",  32'(u_if.done),      32'd1);
      chk("rr_sweep_cnt", 32'(u_if.sweep_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
